// File: rtl/pc_seq_ctrl.sv
// Fetch/branch sequencer for the ONC-16 program counter: drives PC enables and
// branch selects, handshakes with imem, waits on execute, and supports halt/timeout.
module pc_seq_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic             clock,
    input  logic             n_rst,
    input  logic             imem_ack,
    input  logic             br_req,
    input  logic             br_mode,
    input  logic [2:0]       br_cond,
    input  logic             flag_z,
    input  logic             flag_c,
    input  logic             flag_n,
    input  logic             ex_busy,
    input  logic             halt_req,
    input  logic             resume,
    output logic             imem_req,
    output logic             ir_load,
    output logic             pc_en,
    output logic             br_sel,
    output logic             imr_sel,
    output logic             halted,
    output logic             fetch_err,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        EXWAIT = 2'd2,
        HALT   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  taken_q, taken_d;

    logic imem_req_c, ir_load_c, pc_en_c, br_sel_c, imr_sel_c, halted_c;
    logic taken;

    function automatic logic cond_true(input logic [2:0] cond,
                                       input logic z, input logic c, input logic n);
        case (cond)
            3'b000:  cond_true = 1'b1;
            3'b001:  cond_true = z;
            3'b010:  cond_true = ~z;
            3'b011:  cond_true = c;
            3'b100:  cond_true = ~c;
            3'b101:  cond_true = n;
            3'b110:  cond_true = ~n;
            default: cond_true = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= FETCH;
            to_cnt_q <= '0;
            err_q    <= 1'b0;
            taken_q  <= '0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
            taken_q  <= taken_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        to_cnt_d   = to_cnt_q;
        err_d      = err_q;
        taken_d    = taken_q;
        imem_req_c = 1'b0;
        ir_load_c  = 1'b0;
        pc_en_c    = 1'b0;
        br_sel_c   = 1'b0;
        imr_sel_c  = 1'b0;
        halted_c   = 1'b0;
        taken      = br_req & cond_true(br_cond, flag_z, flag_c, flag_n);

        case (state_q)
            FETCH: begin
                imem_req_c = 1'b1;
                if (imem_ack) begin
                    ir_load_c = 1'b1;
                    to_cnt_d  = '0;
                    state_d   = DECODE;
                end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    // This cycle is the TIMEOUT-th without an ack.
                    to_cnt_d = '0;
                    err_d    = 1'b1;
                    state_d  = HALT;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            DECODE, EXWAIT: begin
                if (ex_busy) begin
                    state_d = EXWAIT;
                end else begin
                    pc_en_c   = 1'b1;
                    br_sel_c  = taken;
                    imr_sel_c = taken & br_mode;
                    state_d   = halt_req ? HALT : FETCH;
                end
            end
            default: begin
                halted_c = 1'b1;
                if (resume) begin
                    state_d = FETCH;
                end
            end
        endcase

        if (pc_en_c && br_sel_c && (taken_q != {CNT_W{1'b1}})) begin
            taken_d = taken_q + 1'b1;
        end
    end

    // Combinational outputs are forced low while reset is held.
    assign imem_req  = n_rst & imem_req_c;
    assign ir_load   = n_rst & ir_load_c;
    assign pc_en     = n_rst & pc_en_c;
    assign br_sel    = n_rst & br_sel_c;
    assign imr_sel   = n_rst & imr_sel_c;
    assign halted    = n_rst & halted_c;
    assign fetch_err = err_q;
    assign taken_cnt = taken_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Randomized self-checking bench for pc_seq_ctrl against an instruction-level
// model of the sequencer, plus directed scenarios pinned with literal values.
module tb_pc_seq_ctrl;

    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 12;
    localparam int TO_W    = 4;
    localparam int MAXC    = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             n_rst;
    logic             imem_ack, br_req, br_mode, flag_z, flag_c, flag_n;
    logic             ex_busy, halt_req, resume;
    logic [2:0]       br_cond;
    logic             imem_req, ir_load, pc_en, br_sel, imr_sel, halted, fetch_err;
    logic [CNT_W-1:0] taken_cnt;

    pc_seq_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
        .clock(clock), .n_rst(n_rst), .imem_ack(imem_ack), .br_req(br_req),
        .br_mode(br_mode), .br_cond(br_cond), .flag_z(flag_z), .flag_c(flag_c),
        .flag_n(flag_n), .ex_busy(ex_busy), .halt_req(halt_req), .resume(resume),
        .imem_req(imem_req), .ir_load(ir_load), .pc_en(pc_en), .br_sel(br_sel),
        .imr_sel(imr_sel), .halted(halted), .fetch_err(fetch_err), .taken_cnt(taken_cnt)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: what the sequencer is waiting for.
    // 0 = an instruction word, 1 = execution to finish, 2 = a resume.
    int waiting_for;
    int no_ack_cycles;
    int err_m;
    int cnt_m;

    // Observed outputs of the most recent step (for literal pins).
    logic o_ir_load, o_pc_en, o_br_sel, o_imr_sel;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit cond_holds(input logic [2:0] cond, input logic z,
                                      input logic c, input logic n);
        logic [7:0] table_v;
        table_v = {1'b0, ~n, n, ~c, c, ~z, z, 1'b1};
        return table_v[cond];
    endfunction

    task automatic model_reset();
        waiting_for   = 0;
        no_ack_cycles = 0;
        err_m         = 0;
        cnt_m         = 0;
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic step(input logic ack, input logic br, input logic mode,
                        input logic [2:0] cond, input logic z, input logic c,
                        input logic n, input logic busy, input logic hreq,
                        input logic res);
        bit tk;
        int e_req, e_ld, e_en, e_bs, e_is, e_h;
        imem_ack = ack; br_req = br; br_mode = mode; br_cond = cond;
        flag_z = z; flag_c = c; flag_n = n; ex_busy = busy;
        halt_req = hreq; resume = res;
        tk = br && cond_holds(cond, z, c, n);
        e_req = (waiting_for == 0);
        e_ld  = (waiting_for == 0) && ack;
        e_en  = (waiting_for == 1) && !busy;
        e_bs  = e_en && tk;
        e_is  = e_bs && mode;
        e_h   = (waiting_for == 2);
        #3;
        chk("imem_req", imem_req, e_req);
        chk("ir_load", ir_load, e_ld);
        chk("pc_en", pc_en, e_en);
        chk("br_sel", br_sel, e_bs);
        chk("imr_sel", imr_sel, e_is);
        chk("halted", halted, e_h);
        chk("fetch_err", fetch_err, err_m);
        chk("taken_cnt", taken_cnt, cnt_m);
        o_ir_load = ir_load; o_pc_en = pc_en; o_br_sel = br_sel; o_imr_sel = imr_sel;
        @(posedge clock);
        case (waiting_for)
            0: begin
                if (ack) begin
                    waiting_for = 1;
                    no_ack_cycles = 0;
                end else begin
                    no_ack_cycles++;
                    if (no_ack_cycles == TIMEOUT) begin
                        err_m = 1;
                        waiting_for = 2;
                        no_ack_cycles = 0;
                    end
                end
            end
            1: begin
                if (!busy) begin
                    if (tk && cnt_m < MAXC) cnt_m++;
                    waiting_for = hreq ? 2 : 0;
                end
            end
            default: if (res) waiting_for = 0;
        endcase
        #1;
    endtask

    task automatic idle(input logic ack);
        step(ack, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Reset pulse with hostile inputs so output gating is exercised.
    task automatic apply_reset();
        imem_ack = 1'b1; br_req = 1'b1; br_cond = 3'b000; ex_busy = 1'b0;
        resume = 1'b1; halt_req = 1'b0;
        n_rst = 1'b0;
        #2;
        chk("rst_imem_req", imem_req, 0);
        chk("rst_ir_load", ir_load, 0);
        chk("rst_pc_en", pc_en, 0);
        chk("rst_br_sel", br_sel, 0);
        chk("rst_imr_sel", imr_sel, 0);
        chk("rst_halted", halted, 0);
        chk("rst_fetch_err", fetch_err, 0);
        chk("rst_taken_cnt", taken_cnt, 0);
        @(posedge clock);
        #1;
        n_rst = 1'b1;
        model_reset();
    endtask

    initial begin
        int ack_pct;
        n_rst = 1'b0;
        imem_ack = 0; br_req = 0; br_mode = 0; br_cond = 0;
        flag_z = 0; flag_c = 0; flag_n = 0; ex_busy = 0; halt_req = 0; resume = 0;
        model_reset();
        @(posedge clock);
        #1;
        apply_reset();

        // Straight-line code: pc_en on every second cycle.
        for (int i = 0; i < 20; i++) begin
            idle(1'b1);
            chk("lin_ir_load", o_ir_load, 1);
            idle(1'b0);
            chk("lin_pc_en", o_pc_en, 1);
        end

        // Unconditional relative branch.
        idle(1'b1);
        step(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("uncond_br_sel", o_br_sel, 1);
        chk("uncond_imr_sel", o_imr_sel, 0);
        chk("uncond_cnt", taken_cnt, 1);

        // Branch on Z, not taken then taken absolute.
        idle(1'b1);
        step(1'b0, 1'b1, 1'b0, 3'b001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("bz_nt_br_sel", o_br_sel, 0);
        chk("bz_nt_pc_en", o_pc_en, 1);
        idle(1'b1);
        step(1'b0, 1'b1, 1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("bz_t_imr_sel", o_imr_sel, 1);
        chk("bz_t_cnt", taken_cnt, 2);

        // Multi-cycle execute: flags of the release cycle decide the branch.
        idle(1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            chk("busy_pc_en", o_pc_en, 0);
        end
        step(1'b0, 1'b1, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("busy_rel_br_sel", o_br_sel, 1);

        // Fetch timeout.
        for (int i = 0; i < TIMEOUT - 1; i++) idle(1'b0);
        chk("to_pre_halted", halted, 0);
        idle(1'b0);
        chk("to_halted", halted, 1);
        chk("to_err", fetch_err, 1);
        step(1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("to_resume_req", imem_req, 1);
        chk("to_err_sticky", fetch_err, 1);

        // Taken branch together with halt request.
        idle(1'b1);
        step(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("bh_br_sel", o_br_sel, 1);
        chk("bh_halted", halted, 1);
        step(1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        apply_reset();
        chk("mid_rst_err", fetch_err, 0);

        // Counter saturation.
        for (int i = 0; i < MAXC + 3; i++) begin
            idle(1'b1);
            step(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("sat_cnt", taken_cnt, MAXC);

        // Randomized operation.
        ack_pct = 90;
        for (int i = 0; i < 4000; i++) begin
            if (i % 100 == 0) begin
                case ($urandom_range(0, 2))
                    0: ack_pct = 90;
                    1: ack_pct = 50;
                    default: ack_pct = 4;
                endcase
            end
            if ($urandom_range(0, 249) == 0) begin
                apply_reset();
            end else begin
                step(($urandom_range(0, 99) < ack_pct), 1'($urandom), 1'($urandom),
                     3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                     ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 10),
                     ($urandom_range(0, 99) < 30));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
